// File: rtl/game_tick_scheduler_pkg.sv
// Shared definitions for the game run controller: state encodings, timing
// constants and the BCD increment helper used by the score counter.
package game_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2,
        ST_OVER   = 2'd3
    } state_e;

    localparam int          CYCLES_PER_FRAME_60HZ = 833333;
    localparam logic [15:0] SCORE_MAX_BCD         = 16'h9999;

    // Adds one to a 4-digit packed BCD value with ripple carry; no saturation here.
    function automatic logic [15:0] bcd4_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (v[i*4 +: 4] == 4'd9) begin
                    r[i*4 +: 4] = 4'd0;
                end else begin
                    r[i*4 +: 4] = v[i*4 +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end else begin
                r[i*4 +: 4] = v[i*4 +: 4];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/game_tick_scheduler_if.sv
// Player-control inputs and run-status outputs of the tick scheduler.
interface game_tick_scheduler_if;
    logic        start;
    logic        pause;
    logic        collision;
    logic        frame_tick;
    logic        game_tick;
    logic [3:0]  skip;
    logic [15:0] score;
    logic [1:0]  state;

    modport master (
        output start, pause, collision,
        input  frame_tick, game_tick, skip, score, state
    );

    modport slave (
        input  start, pause, collision,
        output frame_tick, game_tick, skip, score, state
    );
endinterface

// File: rtl/game_tick_scheduler_bcd4_counter.sv
// Four-digit BCD score counter, saturating at 9999, with a flag marking an
// increment that wraps the low two digits to 00.
module bcd4_counter
    import game_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        clear,
    input  logic        inc,
    output logic [15:0] value,
    output logic        roll100
);

    logic [15:0] value_q;
    logic [15:0] value_d;
    logic        can_inc_s;

    // Next score value and hundred-point rollover flag.
    always_comb begin
        value_d   = value_q;
        can_inc_s = inc && (value_q != SCORE_MAX_BCD);
        roll100   = 1'b0;
        if (clear) begin
            value_d = 16'h0000;
        end else if (can_inc_s) begin
            value_d = bcd4_inc(value_q);
            roll100 = (value_q[7:0] == 8'h99);
        end else begin
            value_d = value_q;
        end
    end

    // Score register.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            value_q <= 16'h0000;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule

// File: rtl/game_tick_scheduler.sv
// Game loop run controller: frame strobe, frame-skipped game strobe, game
// state machine and score-driven speed-up.
module game_tick_scheduler
    import game_pkg::*;
#(
    parameter int         CYCLES_PER_FRAME = CYCLES_PER_FRAME_60HZ,
    parameter logic [3:0] INIT_SKIP        = 4'd7,
    parameter logic [3:0] MIN_SKIP         = 4'd1
) (
    input  logic                 clk,
    input  logic                 resetn,
    game_tick_scheduler_if.slave bus
);

    localparam logic [19:0] FRAME_RELOAD = 20'(CYCLES_PER_FRAME - 1);

    state_e      state_q, state_d;
    logic [19:0] frame_cnt_q, frame_cnt_d;
    logic [3:0]  skip_cnt_q, skip_cnt_d;
    logic [3:0]  skip_q, skip_d;
    logic        frame_tick_s;
    logic        game_tick_s;
    logic        start_new_s;
    logic        roll100_s;
    logic [15:0] score_s;

    bcd4_counter u_score (
        .clk     (clk),
        .resetn  (resetn),
        .clear   (start_new_s),
        .inc     (game_tick_s),
        .value   (score_s),
        .roll100 (roll100_s)
    );

    // Strobe decode, state transitions and counter/skip next values.
    always_comb begin
        frame_tick_s = (state_q == ST_RUN) && (frame_cnt_q == 20'd0);
        game_tick_s  = frame_tick_s && (skip_cnt_q == 4'd0);
        start_new_s  = ((state_q == ST_IDLE) || (state_q == ST_OVER)) && bus.start;
        state_d      = state_q;
        frame_cnt_d  = frame_cnt_q;
        skip_cnt_d   = skip_cnt_q;
        skip_d       = skip_q;

        case (state_q)
            ST_IDLE, ST_OVER: begin
                if (bus.start) state_d = ST_RUN;
                else           state_d = state_q;
            end
            ST_RUN: begin
                if (bus.collision)  state_d = ST_OVER;
                else if (bus.pause) state_d = ST_PAUSED;
                else                state_d = ST_RUN;
            end
            ST_PAUSED: begin
                if (bus.pause) state_d = ST_RUN;
                else           state_d = ST_PAUSED;
            end
            default: state_d = ST_IDLE;
        endcase

        // Counters advance in every RUN cycle, including the one that leaves RUN.
        if (start_new_s) begin
            frame_cnt_d = FRAME_RELOAD;
            skip_cnt_d  = INIT_SKIP;
        end else if (state_q == ST_RUN) begin
            frame_cnt_d = (frame_cnt_q == 20'd0) ? FRAME_RELOAD : (frame_cnt_q - 20'd1);
            if (frame_tick_s) begin
                skip_cnt_d = (skip_cnt_q == 4'd0) ? skip_q : (skip_cnt_q - 4'd1);
            end else begin
                skip_cnt_d = skip_cnt_q;
            end
        end else begin
            frame_cnt_d = frame_cnt_q;
            skip_cnt_d  = skip_cnt_q;
        end

        // A new skip value only reaches skip_cnt at its next reload.
        if (start_new_s) begin
            skip_d = INIT_SKIP;
        end else if (roll100_s && (skip_q > MIN_SKIP)) begin
            skip_d = skip_q - 4'd1;
        end else begin
            skip_d = skip_q;
        end
    end

    // State, frame/skip counters and skip register.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            frame_cnt_q <= FRAME_RELOAD;
            skip_cnt_q  <= INIT_SKIP;
            skip_q      <= INIT_SKIP;
        end else begin
            state_q     <= state_d;
            frame_cnt_q <= frame_cnt_d;
            skip_cnt_q  <= skip_cnt_d;
            skip_q      <= skip_d;
        end
    end

    assign bus.frame_tick = frame_tick_s;
    assign bus.game_tick  = game_tick_s;
    assign bus.skip       = skip_q;
    assign bus.score      = score_s;
    assign bus.state      = state_q;

endmodule

// File: tb/tb_game_tick_scheduler.sv
// Directed bench for game_tick_scheduler with a time-based reference model and
// a queue of expected score/skip values due one cycle after each game tick.
module tb_game_tick_scheduler;
    import game_pkg::*;

    localparam int CPF  = 4;
    localparam int INIT = 2;
    localparam int MINS = 0;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    game_tick_scheduler_if bus ();

    game_tick_scheduler #(
        .CYCLES_PER_FRAME (CPF),
        .INIT_SKIP        (4'(INIT)),
        .MIN_SKIP         (4'(MINS))
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    typedef struct {
        int due;
        int score;
        int skip;
    } sb_t;

    sb_t sb_q[$];
    int  n_tests = 0;
    int  n_fail  = 0;
    int  cyc     = 0;
    int  m_state = 0;
    int  ft_next = 0;
    int  f_left  = 0;
    int  m_score = 0;
    int  m_skip  = INIT;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic int dec2bcd(input int d);
        return (((d / 1000) % 10) << 12) | (((d / 100) % 10) << 8) |
               (((d / 10) % 10) << 4) | (d % 10);
    endfunction

    // One clock: apply the inputs seen at this edge to the model, compare, then
    // advance the model's frame/game schedule.
    task automatic step();
        bit  e_ft;
        bit  e_gt;
        sb_t e;
        @(posedge clk);
        #1;
        cyc++;
        if (!resetn) begin
            m_state = 0;
            m_score = 0;
            m_skip  = INIT;
            sb_q.delete();
            sb_q.push_back('{due: cyc, score: 0, skip: INIT});
        end else begin
            case (m_state)
                0, 3: if (bus.start) begin
                    m_state = 1;
                    ft_next = cyc + CPF - 1;
                    f_left  = INIT + 1;
                    m_score = 0;
                    m_skip  = INIT;
                    sb_q.push_back('{due: cyc, score: 0, skip: INIT});
                end
                1: begin
                    if (bus.collision)  m_state = 3;
                    else if (bus.pause) m_state = 2;
                end
                2: if (bus.pause) m_state = 1;
                default: ;
            endcase
        end
        if (m_state == 2) ft_next++;
        e_ft = (m_state == 1) && (cyc == ft_next);
        e_gt = e_ft && (f_left == 1);
        chk("state", 32'(bus.state), 32'(m_state));
        chk("frame_tick", 32'(bus.frame_tick), 32'(e_ft));
        chk("game_tick", 32'(bus.game_tick), 32'(e_gt));
        while (sb_q.size() > 0 && sb_q[0].due == cyc) begin
            e = sb_q.pop_front();
            chk("score", 32'(bus.score), 32'(dec2bcd(e.score)));
            chk("skip", 32'(bus.skip), 32'(e.skip));
        end
        if (e_ft) begin
            ft_next += CPF;
            if (e_gt) begin
                f_left = m_skip + 1;
                if (m_score < 9999) begin
                    m_score++;
                    if ((m_score % 100 == 0) && (m_skip > MINS)) m_skip--;
                end
                sb_q.push_back('{due: cyc + 1, score: m_score, skip: m_skip});
            end else begin
                f_left--;
            end
        end
    endtask

    task automatic wait_gt(output int t);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!bus.game_tick && n < 200);
        chk("wait_gt_timeout", 32'(n < 200), 32'd1);
        t = cyc;
    endtask

    initial begin
        int n;
        int t0;
        int t1;
        int t2;
        bus.start     = 1'b0;
        bus.pause     = 1'b0;
        bus.collision = 1'b0;

        // Reset state
        resetn = 1'b0;
        step();
        step();
        chk("rst_state", 32'(bus.state), 32'd0);
        chk("rst_score", 32'(bus.score), 32'h0000);
        chk("rst_skip", 32'(bus.skip), 32'd2);
        resetn = 1'b1;
        step();

        // Start: frame ticks every 4 RUN cycles, game ticks on 12 and 24
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        chk("t1_run", 32'(bus.state), 32'd1);
        repeat (11) step();
        chk("t1_gt12", 32'(bus.game_tick), 32'd1);
        step();
        chk("t1_score1", 32'(bus.score), 32'h0001);
        repeat (11) step();
        chk("t1_gt24", 32'(bus.game_tick), 32'd1);

        // Collision coincident with a game tick
        wait_gt(t0);
        bus.collision = 1'b1;
        step();
        bus.collision = 1'b0;
        chk("t4_over", 32'(bus.state), 32'd3);
        chk("t4_score", 32'(bus.score), 32'h0003);
        repeat (10) step();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        chk("t4_restart_score", 32'(bus.score), 32'h0000);
        chk("t4_restart_skip", 32'(bus.skip), 32'd2);
        chk("t4_restart_state", 32'(bus.state), 32'd1);

        // Pause at RUN cycle 6 for 20 cycles, then resume
        repeat (5) step();
        bus.pause = 1'b1;
        step();
        bus.pause = 1'b0;
        chk("t3_paused", 32'(bus.state), 32'd2);
        repeat (19) step();
        bus.pause = 1'b1;
        step();
        bus.pause = 1'b0;
        chk("t3_resumed", 32'(bus.state), 32'd1);
        chk("t3_no_ft_yet", 32'(bus.frame_tick), 32'd0);
        step();
        chk("t3_resume_ft", 32'(bus.frame_tick), 32'd1);

        // Reset one cycle before a frame tick
        n = 0;
        while (!(m_state == 1 && ft_next == cyc + 1) && n < 20) begin
            step();
            n++;
        end
        chk("t6_sync_timeout", 32'(n < 20), 32'd1);
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        chk("t6_idle", 32'(bus.state), 32'd0);
        chk("t6_no_ft", 32'(bus.frame_tick), 32'd0);
        chk("t6_score", 32'(bus.score), 32'h0000);
        chk("t6_skip", 32'(bus.skip), 32'd2);
        repeat (6) step();

        // Speed-up at score 100 and tick spacing around it
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        n = 0;
        while (bus.score != 16'h0100 && n < 2000) begin
            step();
            n++;
        end
        chk("t2_reach100", 32'(bus.score), 32'h0100);
        chk("t2_skip1", 32'(bus.skip), 32'd1);
        t0 = cyc - 1;
        wait_gt(t1);
        wait_gt(t2);
        chk("t2_gap12", 32'(t1 - t0), 32'd12);
        chk("t2_gap8", 32'(t2 - t1), 32'd8);

        // Saturation at 9999 with skip at its floor
        n = 0;
        while (bus.score != 16'h9999 && n < 50000) begin
            step();
            n++;
        end
        chk("t5_reach9999", 32'(bus.score), 32'h9999);
        repeat (40) step();
        chk("t5_sat_score", 32'(bus.score), 32'h9999);
        chk("t5_skip0", 32'(bus.skip), 32'd0);
        chk("t5_state", 32'(bus.state), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
